// File: rtl/ahb_pkg.sv
// Shared AHB encodings, responder data-phase states and a transfer-size helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011,
        HSIZE_4W    = 3'b100,
        HSIZE_8W    = 3'b101,
        HSIZE_16W   = 3'b110,
        HSIZE_32W   = 3'b111
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        D_IDLE,
        D_WAIT,
        D_ACCESS,
        D_ERR1,
        D_ERR2
    } dstate_e;

    function automatic logic [31:0] size_bytes(input logic [2:0] hsize);
        return 32'd1 << hsize;
    endfunction

endpackage

// File: rtl/ahb_lane_mask.sv
// Byte-lane enables for one transfer: lanes lo .. lo + 2**hsize - 1 of the data bus.
module ahb_lane_mask
    import ahb_pkg::*;
#(
    parameter int NB = 8,
    parameter int LW = $clog2(NB)
) (
    input  logic [LW-1:0] addr,
    input  logic [2:0]    hsize,
    output logic [NB-1:0] be,
    output logic [LW-1:0] lo
);

    logic [31:0] span;

    assign lo   = addr;
    assign span = size_bytes(hsize);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_be
            assign be[gi] = (32'(gi) >= 32'(addr)) && (32'(gi) < 32'(addr) + span);
        end
    endgenerate

endmodule

// File: rtl/ahb_s_mem.sv
// AHB responder backed by byte-lane local memory; optional NONSEQ wait states
// are enabled by defining AHB_S_WAIT_EN.
module ahb_s_mem
    import ahb_pkg::*;
#(
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int AHB_ADDRESS_WIDTH = 32,
    parameter int MEM_BYTES         = 1024,
    parameter int WAIT_CYCLES       = 2
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [2:0]                   HBURST,
    input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
    output logic [AHB_DATA_WIDTH-1:0]    HRDATA,
    output logic                         HREADY,
    output logic                         HRESP
);

    localparam int AW   = AHB_ADDRESS_WIDTH;
    localparam int NB   = AHB_DATA_WIDTH / 8;
    localparam int LW   = $clog2(NB);
    localparam int ROWS = MEM_BYTES / NB;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

`ifdef AHB_S_WAIT_EN
    localparam bit WAIT_ON = (WAIT_CYCLES > 0);
`else
    localparam bit WAIT_ON = 1'b0;
`endif

    dstate_e           state_reg, state_next;
    logic [7:0]        wait_cnt_reg, wait_cnt_next;
    logic [LW+RW-1:0]  addr_reg;
    logic [2:0]        size_reg;
    logic              write_reg;
    logic              capture, legal;

    logic [LW+RW-1:0]  rd_addr;
    logic [2:0]        rd_size;
    logic              rd_load, wr_en;
    logic [RW-1:0]     rd_row, wr_row;
    logic [NB-1:0]     rd_be, wr_be, fwd;
    logic [NB-1:0]     rd_be_reg, fwd_sel_reg;
    logic [LW-1:0]     rd_lo, wr_lo;
    logic              unused_bits;

    assign HREADY = !(state_reg == D_WAIT || state_reg == D_ERR1);
    assign HRESP  = (state_reg == D_ERR1 || state_reg == D_ERR2) ? HRESP_ERROR : HRESP_OKAY;

    assign capture = HREADY && HTRANS[1];
    assign legal   = (HADDR < AW'(MEM_BYTES))
                  && (size_bytes(HSIZE) <= 32'(NB))
                  && ((HADDR & AW'(size_bytes(HSIZE) - 32'd1)) == '0);

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            D_WAIT: begin
                wait_cnt_next = wait_cnt_reg - 8'd1;
                if (wait_cnt_reg == 8'd1)
                    state_next = D_ACCESS;
            end
            D_ERR1: state_next = D_ERR2;
            default: begin
                // D_IDLE, D_ACCESS and D_ERR2 all accept a new address phase
                if (!capture)
                    state_next = D_IDLE;
                else if (!legal)
                    state_next = D_ERR1;
                else if (WAIT_ON && htrans_e'(HTRANS) == HTRANS_NONSEQ) begin
                    state_next    = D_WAIT;
                    wait_cnt_next = 8'(WAIT_CYCLES);
                end else
                    state_next = D_ACCESS;
            end
        endcase
    end

    // Zero-wait reads take their address straight off the bus; waited ones use the captured copy.
    assign rd_addr = (state_reg == D_WAIT) ? addr_reg : HADDR[LW+RW-1:0];
    assign rd_size = (state_reg == D_WAIT) ? size_reg : HSIZE;
    assign rd_load = (state_next == D_ACCESS) && !((state_reg == D_WAIT) ? write_reg : HWRITE);
    assign wr_en   = (state_reg == D_ACCESS) && write_reg;
    assign rd_row  = rd_addr[LW +: RW];
    assign wr_row  = addr_reg[LW +: RW];

    ahb_lane_mask #(.NB(NB), .LW(LW)) u_wr_mask (
        .addr  (addr_reg[LW-1:0]),
        .hsize (size_reg),
        .be    (wr_be),
        .lo    (wr_lo)
    );

    ahb_lane_mask #(.NB(NB), .LW(LW)) u_rd_mask (
        .addr  (rd_addr[LW-1:0]),
        .hsize (rd_size),
        .be    (rd_be),
        .lo    (rd_lo)
    );

    assign unused_bits = ^{HBURST, wr_lo, rd_lo};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg    <= D_IDLE;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            size_reg     <= '0;
            write_reg    <= 1'b0;
            rd_be_reg    <= '0;
            fwd_sel_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (capture) begin
                addr_reg  <= HADDR[LW+RW-1:0];
                size_reg  <= HSIZE;
                write_reg <= HWRITE;
            end
            if (rd_load) begin
                rd_be_reg   <= rd_be;
                fwd_sel_reg <= fwd;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem [ROWS];
            logic [7:0] raw_reg;
            logic [7:0] fwd_byte_reg;

            assign fwd[gi] = wr_en && wr_be[gi] && (wr_row == rd_row);

            always_ff @(posedge HCLK) begin
                if (wr_en && wr_be[gi])
                    mem[wr_row] <= HWDATA[gi*8 +: 8];
                if (rd_load) begin
                    raw_reg      <= mem[rd_row];
                    fwd_byte_reg <= HWDATA[gi*8 +: 8];
                end
            end

            assign HRDATA[gi*8 +: 8] = !rd_be_reg[gi]    ? 8'h00 :
                                       fwd_sel_reg[gi]   ? fwd_byte_reg : raw_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ahb_s_mem.sv
// Directed pipelined-master bench for ahb_s_mem (64-bit bus, 1 KiB, WAIT_CYCLES=2).
module tb_ahb_s_mem;

`ifdef AHB_S_WAIT_EN
    localparam int NSW = 2;
`else
    localparam int NSW = 0;
`endif
    localparam int NV = 40;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb_s_mem #(
        .AHB_DATA_WIDTH(64), .AHB_ADDRESS_WIDTH(32), .MEM_BYTES(1024), .WAIT_CYCLES(2)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_resp;
        int          exp_waits;
        bit          chk_rd;
    } vec_t;

    vec_t        vtab [NV];
    int          nvec;
    logic        got_resp  [NV];
    logic [63:0] got_rdata [NV];
    int          got_waits [NV];
    bit          got_err1  [NV];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic void add(input logic [1:0] t, input logic [31:0] a, input logic [2:0] s,
                                input logic w, input logic [63:0] wd, input logic [63:0] er,
                                input logic eresp, input int ew, input bit cr);
        vtab[nvec] = '{t, a, s, w, wd, er, eresp, ew, cr};
        nvec++;
    endfunction

    function automatic logic [63:0] pat(input int k);
        logic [7:0] b;
        b = 8'(16 + k);
        return {8{b}};
    endfunction

    task automatic drive_beat(input int i);
        if (i >= 0) begin
            HTRANS = vtab[i].trans;
            HADDR  = vtab[i].addr;
            HSIZE  = vtab[i].size;
            HWRITE = vtab[i].write;
        end else begin
            HTRANS = 2'b00;
            HADDR  = '0;
            HSIZE  = '0;
            HWRITE = 1'b0;
        end
    endtask

    // Address phase of beat cur overlaps the data phase of beat dph, as a real master would.
    task automatic run_stream(input int first, input int last);
        int   cur, dph, cyc;
        logic rdy;
        cur = first;
        dph = -1;
        cyc = 0;
        for (int i = first; i < last; i++) begin
            got_waits[i] = 0;
            got_err1[i]  = 1'b0;
            got_resp[i]  = 1'b0;
            got_rdata[i] = '0;
        end
        @(posedge HCLK);
        #1;
        drive_beat(cur);
        while (dph >= 0 || cur < last) begin
            @(negedge HCLK);
            rdy = HREADY;
            if (dph >= 0) begin
                if (!rdy) begin
                    got_waits[dph]++;
                    if (HRESP) got_err1[dph] = 1'b1;
                end else begin
                    got_resp[dph]  = HRESP;
                    got_rdata[dph] = HRDATA;
                end
            end
            @(posedge HCLK);
            #1;
            if (rdy) begin
                dph = (cur < last) ? cur : -1;
                if (cur < last) cur++;
                drive_beat((cur < last) ? cur : -1);
                HWDATA = (dph >= 0) ? vtab[dph].wdata : 64'h0;
            end
            cyc++;
            if (cyc > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: stream %0d..%0d stalled, HREADY=%b", first, last, HREADY);
                break;
            end
        end
    endtask

    initial begin
        HRESETn = 1'b0;
        HBURST  = 3'b001;
        HWDATA  = '0;
        drive_beat(-1);
        nvec = 0;

        // single word write then byte read of lane 6 (bits 55:48), forwarded from the write
        add(2'b10, 32'h4, 3'd2, 1'b1, 64'h44332211_DEADBEEF, 64'h0, 1'b0, NSW, 1'b0);
        add(2'b10, 32'h6, 3'd0, 1'b0, 64'h0, 64'h0033_0000_0000_0000, 1'b0, NSW, 1'b1);
        // INCR4 halfword write then INCR4 halfword read, inactive write lanes carry junk
        add(2'b10, 32'h0, 3'd1, 1'b1, 64'hEEEE_EEEE_EEEE_A0A1, 64'h0, 1'b0, NSW, 1'b0);
        add(2'b11, 32'h2, 3'd1, 1'b1, 64'hEEEE_EEEE_B0B1_EEEE, 64'h0, 1'b0, 0, 1'b0);
        add(2'b11, 32'h4, 3'd1, 1'b1, 64'hEEEE_C0C1_EEEE_EEEE, 64'h0, 1'b0, 0, 1'b0);
        add(2'b11, 32'h6, 3'd1, 1'b1, 64'hD0D1_EEEE_EEEE_EEEE, 64'h0, 1'b0, 0, 1'b0);
        add(2'b10, 32'h0, 3'd1, 1'b0, 64'h0, 64'h0000_0000_0000_A0A1, 1'b0, NSW, 1'b1);
        add(2'b11, 32'h2, 3'd1, 1'b0, 64'h0, 64'h0000_0000_B0B1_0000, 1'b0, 0, 1'b1);
        add(2'b11, 32'h4, 3'd1, 1'b0, 64'h0, 64'h0000_C0C1_0000_0000, 1'b0, 0, 1'b1);
        add(2'b11, 32'h6, 3'd1, 1'b0, 64'h0, 64'hD0D1_0000_0000_0000, 1'b0, 0, 1'b1);
        add(2'b00, 32'h0, 3'd0, 1'b0, 64'h0, 64'h0, 1'b0, 0, 1'b0);
        // INCR8 doubleword write with a BUSY after beat 3, then INCR8 read back
        for (int k = 0; k < 8; k++) begin
            if (k == 3) add(2'b01, 32'h18, 3'd3, 1'b1, 64'h0, 64'h0, 1'b0, 0, 1'b0);
            add((k == 0) ? 2'b10 : 2'b11, 32'(8 * k), 3'd3, 1'b1, pat(k), 64'h0, 1'b0,
                (k == 0) ? NSW : 0, 1'b0);
        end
        for (int k = 0; k < 8; k++)
            add((k == 0) ? 2'b10 : 2'b11, 32'(8 * k), 3'd3, 1'b0, 64'h0, pat(k), 1'b0,
                (k == 0) ? NSW : 0, 1'b1);
        // illegal: out of range, unaligned, oversized; row 0 must be untouched afterwards
        add(2'b10, 32'h400, 3'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1, 1'b0);
        add(2'b10, 32'h2,   3'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1, 1'b0);
        add(2'b10, 32'h0,   3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1, 1'b0);
        add(2'b10, 32'h0,   3'd3, 1'b0, 64'h0, pat(0), 1'b0, NSW, 1'b1);
        // back-to-back write/read of the same row: full and per-byte forwarding
        add(2'b10, 32'h20, 3'd3, 1'b1, 64'hCAFEF00D_12345678, 64'h0, 1'b0, NSW, 1'b0);
        add(2'b10, 32'h20, 3'd3, 1'b0, 64'h0, 64'hCAFEF00D_12345678, 1'b0, NSW, 1'b1);
        add(2'b10, 32'h23, 3'd0, 1'b1, 64'hEEEE_EEEE_5AEE_EEEE, 64'h0, 1'b0, NSW, 1'b0);
        add(2'b10, 32'h20, 3'd2, 1'b0, 64'h0, 64'h0000_0000_5A34_5678, 1'b0, NSW, 1'b1);
        add(2'b00, 32'h0, 3'd0, 1'b0, 64'h0, 64'h0, 1'b0, 0, 1'b0);
        // after the reset sequences: the dropped write at 0x10 left old data
        add(2'b10, 32'h10, 3'd3, 1'b0, 64'h0, pat(2), 1'b0, NSW, 1'b1);

        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("reset HREADY", 64'(HREADY), 64'h1);
        chk("reset HRESP",  64'(HRESP),  64'h0);
        chk("reset HRDATA", HRDATA, 64'h0);
        HRESETn = 1'b1;

        run_stream(0, 37);

        // reset in the middle of a write data phase (D_WAIT or D_ACCESS)
        @(posedge HCLK);
        #1;
        HTRANS = 2'b10; HADDR = 32'h10; HWRITE = 1'b1; HSIZE = 3'd3;
        @(posedge HCLK);
        #1;
        drive_beat(-1);
        HWDATA = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge HCLK);
        chk("midwr HREADY", 64'(HREADY), (NSW > 0) ? 64'h0 : 64'h1);
        chk("midwr HRDATA held", HRDATA, 64'h0000_0000_5A34_5678);
        HRESETn = 1'b0;
        #1;
        chk("midwr rst HREADY", 64'(HREADY), 64'h1);
        chk("midwr rst HRESP",  64'(HRESP),  64'h0);
        chk("midwr rst HRDATA", HRDATA, 64'h0);
        $display("reset mid-write @10: HREADY=%b HRESP=%b HRDATA=%h", HREADY, HRESP, HRDATA);
        @(negedge HCLK);
        HRESETn = 1'b1;
        HWDATA  = '0;

        // reset during the first error cycle
        @(posedge HCLK);
        #1;
        HTRANS = 2'b10; HADDR = 32'h400; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK);
        #1;
        drive_beat(-1);
        @(negedge HCLK);
        chk("err1 HREADY", 64'(HREADY), 64'h0);
        chk("err1 HRESP",  64'(HRESP),  64'h1);
        HRESETn = 1'b0;
        #1;
        chk("err1 rst HREADY", 64'(HREADY), 64'h1);
        chk("err1 rst HRESP",  64'(HRESP),  64'h0);
        $display("reset in ERR1: HREADY=%b HRESP=%b", HREADY, HRESP);
        @(negedge HCLK);
        HRESETn = 1'b1;

        run_stream(37, nvec);

        for (int i = 0; i < nvec; i++) begin
            chk($sformatf("v%0d resp", i), 64'(got_resp[i]), 64'(vtab[i].exp_resp));
            chk($sformatf("v%0d waits", i), 64'(got_waits[i]), 64'(vtab[i].exp_waits));
            if (vtab[i].exp_resp)
                chk($sformatf("v%0d err_cycle1", i), 64'(got_err1[i]), 64'h1);
            if (vtab[i].chk_rd)
                chk($sformatf("v%0d rdata", i), got_rdata[i], vtab[i].exp_rdata);
            $display("v%0d trans=%0d addr=%h size=%0d wr=%0d resp=%0d waits=%0d rdata=%h",
                     i, vtab[i].trans, vtab[i].addr, vtab[i].size, vtab[i].write,
                     got_resp[i], got_waits[i], got_rdata[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
